// File: rtl/mem_bus_controller.sv
// Multi-cycle data-memory access controller: one request at a time, WAIT_CYCLES+1 access cycles, one-cycle response.
// Faulting requests (misaligned / out of range) skip memory and respond the cycle after acceptance.
module mem_bus_controller #(
  parameter int WAIT_CYCLES = 2,
  parameter int MEM_WORDS   = 256,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_valid,
  input  logic                  cpu_req_write,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [31:0]           cpu_req_wdata,
  output logic                  cpu_req_ready,
  output logic                  cpu_resp_valid,
  output logic [31:0]           cpu_resp_rdata,
  output logic                  cpu_resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [31:0]           mem_rdata
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]         CNT_INIT   = CW'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-3:0] WORD_LIMIT = (ADDR_WIDTH-2)'(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  fault_q, fault_d;

  logic accept;
  logic req_fault;

  assign accept    = cpu_req_valid && (state_q == S_IDLE);
  assign req_fault = (cpu_req_addr[1:0] != 2'b00) || (cpu_req_addr[ADDR_WIDTH-1:2] >= WORD_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = req_fault ? S_RESP : S_ACCESS;
      S_ACCESS: if (cnt_q == '0) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Response fields change only when a response is produced, so they stay stable between responses.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    if (accept) begin
      addr_d  = cpu_req_addr;
      wdata_d = cpu_req_wdata;
      write_d = cpu_req_write;
      cnt_d   = CNT_INIT;
      if (req_fault) begin
        rdata_d = '0;
        fault_d = 1'b1;
      end
    end else if (state_q == S_ACCESS) begin
      if (cnt_q == '0) begin
        rdata_d = write_q ? 32'd0 : mem_rdata;
        fault_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    cpu_req_ready  = (state_q == S_IDLE);
    cpu_resp_valid = (state_q == S_RESP);
    mem_re         = (state_q == S_ACCESS) && !write_q;
    mem_we         = (state_q == S_ACCESS) && write_q && (cnt_q == '0);
  end

  assign cpu_resp_rdata = rdata_q;
  assign cpu_resp_fault = fault_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Directed bench: u_w2 (WAIT_CYCLES=2) for load/store/fault/reset cases, u_w0 (WAIT_CYCLES=0) for back-to-back.
module tb_mem_bus_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // DUT with WAIT_CYCLES=2
  logic        v2, w2;
  logic [31:0] a2, d2;
  logic        r2_ready, r2_rv, r2_fault, m2_re, m2_we;
  logic [31:0] r2_rdata, m2_addr, m2_wdata, m2_rdata;

  // DUT with WAIT_CYCLES=0
  logic        v0, w0;
  logic [31:0] a0, d0;
  logic        r0_ready, r0_rv, r0_fault, m0_re, m0_we;
  logic [31:0] r0_rdata, m0_addr, m0_wdata, m0_rdata;

  // Backdoor preload port shared by both memory models
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_dat;

  logic [31:0] mem2 [0:255];
  logic [31:0] mem0 [0:255];

  always @(posedge clk) begin
    if (pre_we) mem2[pre_idx] <= pre_dat;
    else if (m2_we) mem2[m2_addr[9:2]] <= m2_wdata;
  end
  always @(posedge clk) begin
    if (pre_we) mem0[pre_idx] <= pre_dat;
    else if (m0_we) mem0[m0_addr[9:2]] <= m0_wdata;
  end
  assign m2_rdata = mem2[m2_addr[9:2]];
  assign m0_rdata = mem0[m0_addr[9:2]];

  mem_bus_controller #(.WAIT_CYCLES(2), .MEM_WORDS(256), .ADDR_WIDTH(32)) u_w2 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(v2), .cpu_req_write(w2), .cpu_req_addr(a2), .cpu_req_wdata(d2),
    .cpu_req_ready(r2_ready), .cpu_resp_valid(r2_rv), .cpu_resp_rdata(r2_rdata),
    .cpu_resp_fault(r2_fault), .mem_addr(m2_addr), .mem_wdata(m2_wdata),
    .mem_re(m2_re), .mem_we(m2_we), .mem_rdata(m2_rdata)
  );

  mem_bus_controller #(.WAIT_CYCLES(0), .MEM_WORDS(256), .ADDR_WIDTH(32)) u_w0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(v0), .cpu_req_write(w0), .cpu_req_addr(a0), .cpu_req_wdata(d0),
    .cpu_req_ready(r0_ready), .cpu_resp_valid(r0_rv), .cpu_resp_rdata(r0_rdata),
    .cpu_resp_fault(r0_fault), .mem_addr(m0_addr), .mem_wdata(m0_wdata),
    .mem_re(m0_re), .mem_we(m0_we), .mem_rdata(m0_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags2();
    return {28'd0, r2_ready, r2_rv, m2_re, m2_we};
  endfunction

  function automatic logic [31:0] flags0();
    return {28'd0, r0_ready, r0_rv, m0_re, m0_we};
  endfunction

  // One request on u_w2; checks ready/resp_valid/mem_re/mem_we every cycle until back in IDLE.
  task automatic run2(input string tag, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic f, input logic [31:0] er);
    int         lat;
    logic [3:0] ef;
    lat = f ? 1 : 4;
    @(negedge clk);
    chk($sformatf("%s/rdy", tag), 32'(r2_ready), 32'd1);
    v2 = 1'b1; w2 = wr; a2 = a; d2 = d;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      v2 = 1'b0;
      ef = {k > lat, k == lat, !f && !wr && (k < lat), !f && wr && (k == lat - 1)};
      chk($sformatf("%s/c%0d", tag, k), flags2(), {28'd0, ef});
      if (k == lat) begin
        chk($sformatf("%s/rdata", tag), r2_rdata, er);
        chk($sformatf("%s/fault", tag), 32'(r2_fault), 32'(f));
      end
      if (!f && wr && (k == lat - 1)) begin
        chk($sformatf("%s/maddr", tag), m2_addr, a);
        chk($sformatf("%s/mwdata", tag), m2_wdata, d);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v2 = 1'b0; w2 = 1'b0; a2 = '0; d2 = '0;
    v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    pre_we = 1'b0; pre_idx = '0; pre_dat = '0;

    // Reset held low while preloading memory words 0x10, 0x40, 0x3FC
    @(negedge clk); pre_we = 1'b1; pre_idx = 8'd4;   pre_dat = 32'hDEADBEEF;
    @(negedge clk); pre_idx = 8'd16;  pre_dat = 32'hCAFEF00D;
    @(negedge clk); pre_idx = 8'd255; pre_dat = 32'h0BADC0DE;
    @(negedge clk); pre_we = 1'b0;
    chk("rst/flags2", {27'd0, r2_ready, r2_rv, r2_fault, m2_re, m2_we}, 32'b10000);
    chk("rst/rdata2", r2_rdata, 32'd0);
    chk("rst/maddr2", m2_addr, 32'd0);
    chk("rst/mwdata2", m2_wdata, 32'd0);
    chk("rst/flags0", {27'd0, r0_ready, r0_rv, r0_fault, m0_re, m0_we}, 32'b10000);
    chk("rst/rdata0", r0_rdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle/flags2", flags2(), 32'b1000);
      chk("idle/flags0", flags0(), 32'b1000);
    end

    run2("load10",  1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
    run2("store20", 1'b1, 32'h20,  32'h12345678, 1'b0, 32'h0);
    run2("load20",  1'b0, 32'h20,  32'h0,        1'b0, 32'h12345678);
    run2("load3fc", 1'b0, 32'h3FC, 32'h0,        1'b0, 32'h0BADC0DE);
    run2("flt13",   1'b0, 32'h13,  32'h0,        1'b1, 32'h0);
    run2("flt400",  1'b1, 32'h400, 32'hFFFFFFFF, 1'b1, 32'h0);
    chk("flt/mem10", mem2[4], 32'hDEADBEEF);
    run2("load10b", 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);

    // Reset during the first ACCESS cycle of a store to 0x40
    @(negedge clk); v2 = 1'b1; w2 = 1'b1; a2 = 32'h40; d2 = 32'h11111111;
    @(negedge clk); v2 = 1'b0;
    chk("mrst/acc", flags2(), 32'b0000);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst/rst", flags2(), 32'b1000);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mrst/after%0d", k), flags2(), 32'b1000);
    end
    chk("mrst/mem40", mem2[16], 32'hCAFEF00D);

    // WAIT_CYCLES=0: store 0x8 then load 0x8, valid held high throughout
    @(negedge clk);
    chk("b2b/rdy", 32'(r0_ready), 32'd1);
    v0 = 1'b1; w0 = 1'b1; a0 = 32'h8; d0 = 32'h55AA55AA;
    @(negedge clk);
    chk("b2b/st_acc", flags0(), 32'b0001);
    chk("b2b/st_maddr", m0_addr, 32'h8);
    chk("b2b/st_mwdata", m0_wdata, 32'h55AA55AA);
    w0 = 1'b0;
    @(negedge clk);
    chk("b2b/st_resp", flags0(), 32'b0100);
    chk("b2b/st_rdata", r0_rdata, 32'd0);
    chk("b2b/st_fault", 32'(r0_fault), 32'd0);
    @(negedge clk);
    chk("b2b/idle", flags0(), 32'b1000);
    @(negedge clk);
    chk("b2b/ld_acc", flags0(), 32'b0010);
    v0 = 1'b0;
    @(negedge clk);
    chk("b2b/ld_resp", flags0(), 32'b0100);
    chk("b2b/ld_rdata", r0_rdata, 32'h55AA55AA);
    @(negedge clk);
    chk("b2b/end", flags0(), 32'b1000);
    chk("b2b/hold", r0_rdata, 32'h55AA55AA);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
